// File: rtl/alu_trace_capture_if.sv
// ---------------------------------------------------------------------------
// alu_trace_capture_if
// Bundles the sampled CPU ALU buses, the capture controls and the trace read
// port of alu_trace_capture.
//
//   slave  (trace block) : a, b, v, n, c, z, arm, stop, rd_ready in;
//                          rd_valid, rd_data, count, state out
//   master (CPU/consumer): the mirror image of slave
//
// DEPTH must match the DEPTH of the attached alu_trace_capture.
// Optional feature macro: TRACE_TIMESTAMP_EN widens rd_data to 84 bits.
// ---------------------------------------------------------------------------
interface alu_trace_capture_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int RW = 84;
`else
    localparam int RW = 68;
`endif

    logic [31:0]   a;
    logic [31:0]   b;
    logic          v;
    logic          n;
    logic          c;
    logic          z;
    logic          arm;
    logic          stop;
    logic          rd_ready;
    logic          rd_valid;
    logic [RW-1:0] rd_data;
    logic [CW-1:0] count;
    logic [1:0]    state;

    modport master (
        output a, b, v, n, c, z, arm, stop, rd_ready,
        input  rd_valid, rd_data, count, state
    );

    modport slave (
        input  a, b, v, n, c, z, arm, stop, rd_ready,
        output rd_valid, rd_data, count, state
    );
endinterface

// File: rtl/alu_trace_capture.sv
// ---------------------------------------------------------------------------
// alu_trace_capture
// Watches the CPU ALU buses {v,n,c,z,a,b} every cycle and, during a capture
// session, pushes every sample that differs from the previous cycle's sample
// into a DEPTH-entry FIFO. The FIFO drains through a ready/valid read port
// with zero read latency.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - alu_trace_capture_if.slave
//            a, b, v, n, c, z : sampled ALU buses and flags
//            arm / stop       : one-cycle session start / end pulses
//            rd_ready         : consumer accepts head entry
//            rd_valid         : FIFO non-empty
//            rd_data          : head entry {v,n,c,z,a,b} (timestamp as MSBs)
//            count            : number of stored entries
//            state            : IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//
// Optional feature macro: TRACE_TIMESTAMP_EN -- when defined, a 16-bit
// free-running cycle counter is stored with each entry in rd_data[83:68].
// ---------------------------------------------------------------------------
module alu_trace_capture #(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_trace_capture_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = 68;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = SW + 16;
`else
    localparam int EW = SW;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        st;
    logic [SW-1:0] smp_p0;
    logic [SW-1:0] smp_p1;
    logic          change;
    logic          active;
    logic          has_space;
    logic          push;
    logic          pop;
    logic          fills;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] mem [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]   ts;
`endif

    // Stage p0: current sample and push/pop decisions
    assign smp_p0    = {bus.v, bus.n, bus.c, bus.z, bus.a, bus.b};
    assign change    = (smp_p0 != smp_p1);
    assign active    = (st == ARMED) || (st == CAPTURE);
    assign has_space = (cnt < CW'(DEPTH));
    assign push      = active && change && has_space;
    assign pop       = (cnt != '0) && bus.rd_ready;
    // A pop in the same cycle keeps the level below DEPTH, so only an
    // unpaired push into the last free slot ends the session.
    assign fills     = push && !pop && (cnt == CW'(DEPTH - 1));

`ifdef TRACE_TIMESTAMP_EN
    assign wr_entry = {ts, smp_p0};
`else
    assign wr_entry = smp_p0;
`endif

    // Stage p1: session FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.arm && !bus.stop) st <= ARMED;
                end
                ARMED: begin
                    // A change that cannot be stored (re-armed while full)
                    // ends the session rather than silently skipping data.
                    if (bus.stop || fills || (change && !has_space)) st <= DONE;
                    else if (change)                                 st <= CAPTURE;
                end
                CAPTURE: begin
                    if (bus.stop || fills) st <= DONE;
                end
                DONE: begin
                    if (bus.arm && !bus.stop) st <= ARMED;
                end
                default: st <= IDLE;
            endcase
        end
    end

    // Stage p1: sample register, pointers, occupancy, timestamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_p1 <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            smp_p1 <= smp_p0;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else     ts <= ts + 16'd1;
    end
`endif

    // Stage p1: storage array (data only, never reset)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign bus.rd_valid = (cnt != '0);
    assign bus.rd_data  = mem[rd_ptr];
    assign bus.count    = cnt;
    assign bus.state    = st;
endmodule

// File: tb/tb_alu_trace_capture.sv
// ---------------------------------------------------------------------------
// tb_alu_trace_capture
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based reference model of the capture session and FIFO.
// ---------------------------------------------------------------------------
module tb_alu_trace_capture;
    localparam int DEPTH = 16;
`ifdef TRACE_TIMESTAMP_EN
    localparam int RW = 84;
`else
    localparam int RW = 68;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_trace_capture_if #(.DEPTH(DEPTH)) bus ();

    alu_trace_capture #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model: session state (0 idle, 1 armed, 2 capture, 3 done),
    // previous sample, cycle counter and the FIFO contents as a queue.
    int            m_st;
    logic [67:0]   m_smp;
    logic [15:0]   m_ts;
    logic [RW-1:0] q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [67:0]   cur;
        logic [RW-1:0] ent;
        bit            chg;
        bit            pp;
        bit            ps;
        int            nst;
        cur = {bus.v, bus.n, bus.c, bus.z, bus.a, bus.b};
        chg = (cur != m_smp);
        pp  = (q.size() > 0) && bus.rd_ready;
        ps  = (m_st == 1 || m_st == 2) && chg && (q.size() < DEPTH);
        nst = m_st;
        if (m_st == 0 || m_st == 3) begin
            if (bus.arm && !bus.stop) nst = 1;
        end else begin
            if (bus.stop)                                            nst = 3;
            else if (chg && !ps)                                     nst = 3;
            else if (ps && (q.size() - (pp ? 1 : 0) + 1 == DEPTH))   nst = 3;
            else if (chg)                                            nst = 2;
        end
`ifdef TRACE_TIMESTAMP_EN
        ent = {m_ts, cur};
`else
        ent = cur;
`endif
        if (pp) void'(q.pop_front());
        if (ps) q.push_back(ent);
        m_st  = nst;
        m_smp = cur;
        m_ts  = m_ts + 16'd1;
    endtask

    task automatic compare_all();
        check("state", bus.state, m_st);
        check("count", bus.count, q.size());
        check("rd_valid", bus.rd_valid, q.size() != 0);
        if (q.size() != 0) check("rd_data", bus.rd_data, q[0]);
    endtask

    // Inputs are set by the caller just after a falling edge; tick applies
    // one rising edge and compares on the following falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic zero_inputs();
        bus.a = '0; bus.b = '0;
        bus.v = 1'b0; bus.n = 1'b0; bus.c = 1'b0; bus.z = 1'b0;
        bus.arm = 1'b0; bus.stop = 1'b0; bus.rd_ready = 1'b0;
    endtask

    // Called at a falling edge; asserts reset between clock edges and checks
    // that it takes effect before any rising edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        zero_inputs();
        q.delete();
        m_st  = 0;
        m_smp = '0;
        m_ts  = '0;
        #1;
        check("rst_state", bus.state, 0);
        check("rst_count", bus.count, 0);
        check("rst_valid", bus.rd_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        rst = 1'b1;
        zero_inputs();
        @(negedge clk);
        do_reset();

        // Single change after arming: one entry, capture continues
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        bus.a = 32'h5; bus.b = 32'h3; bus.z = 1'b1; tick();
        repeat (3) tick();
        check("one_count", bus.count, 1);
        check("one_data", bus.rd_data[67:0], 68'h1_00000005_00000003);
        check("one_state", bus.state, 2);

        // Fill to DEPTH with 20 changes and no reads
        do_reset();
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.a = 32'h100 + i;
            tick();
        end
        check("full_count", bus.count, 16);
        check("full_state", bus.state, 3);

        // Drain in order
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_a", bus.rd_data[63:32], 32'h100 + i);
            check("drain_valid", bus.rd_valid, 1);
            tick();
        end
        bus.rd_ready = 1'b0;
        check("empty_valid", bus.rd_valid, 0);
        check("empty_count", bus.count, 0);

        // Simultaneous push/pop, then stop with a change
        do_reset();
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.a = 32'h200 + i;
            tick();
        end
        check("five_count", bus.count, 5);
        check("five_state", bus.state, 2);
        bus.rd_ready = 1'b1; bus.a = 32'h300; tick(); bus.rd_ready = 1'b0;
        check("pushpop_count", bus.count, 5);
        bus.stop = 1'b1; bus.a = 32'h301; tick(); bus.stop = 1'b0;
        check("stop_count", bus.count, 6);
        check("stop_state", bus.state, 3);

        // Reset in the middle of a capture
        do_reset();
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.a = 32'h400 + i;
            tick();
        end
        check("seven_count", bus.count, 7);
        do_reset();

`ifdef TRACE_TIMESTAMP_EN
        begin
            logic [15:0] ts0;
            logic [15:0] ts1;
            bus.arm = 1'b1; tick(); bus.arm = 1'b0;
            bus.a = 32'h1; tick();
            tick();
            tick();
            bus.a = 32'h2; tick();
            ts0 = bus.rd_data[83:68];
            bus.rd_ready = 1'b1; tick(); bus.rd_ready = 1'b0;
            ts1 = bus.rd_data[83:68];
            check("ts_delta", ts1 - ts0, 16'd3);
            do_reset();
        end
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.arm      = ($urandom_range(0, 19) == 0);
            bus.stop     = ($urandom_range(0, 29) == 0);
            bus.rd_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) != 0) bus.a = $urandom;
            if ($urandom_range(0, 3) == 0) bus.b = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                bus.v = 1'($urandom_range(0, 1));
                bus.n = 1'($urandom_range(0, 1));
                bus.c = 1'($urandom_range(0, 1));
                bus.z = 1'($urandom_range(0, 1));
            end
            tick();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
